// File: rtl/coo_aggregation_engine.sv
// coo_aggregation_engine
// Walks a COO edge list and, for each edge (row, col), accumulates the FM_WM
// row of col into acc[row] and the FM_WM row of row into acc[col]. Self-loops
// are counted once. Edges with an out-of-range node index set a sticky error
// flag and contribute nothing. Accumulators are read out combinationally.
module coo_aggregation_engine #(
    parameter int NUM_EDGES    = 6,
    parameter int NUM_NODES    = 6,
    parameter int FEATURE_COLS = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 20,
    localparam int IDX_W       = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int EDGE_W      = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               coo_rd_en,
    output logic [EDGE_W-1:0]                  coo_addr,
    input  logic [2*IDX_W-1:0]                 coo_rdata,
    output logic                               fm_wm_rd_en,
    output logic [IDX_W-1:0]                   fm_wm_addr,
    input  logic [FEATURE_COLS*DATA_WIDTH-1:0] fm_wm_rdata,
    input  logic [IDX_W-1:0]                   res_addr,
    output logic [FEATURE_COLS*ACC_WIDTH-1:0]  res_rdata,
    output logic                               busy,
    output logic                               done,
    output logic                               idx_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_COO  = 3'd1,
        LATCH_COO = 3'd2,
        ACC_R_C   = 3'd3,
        ACC_C_R   = 3'd4,
        INCR      = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t                                   state;
    logic [EDGE_W-1:0]                        edge_cnt;
    logic [IDX_W-1:0]                         row_q;
    logic [IDX_W-1:0]                         col_q;
    logic                                     pair_ok;
    logic [IDX_W-1:0]                         fm_addr_q;
    logic [FEATURE_COLS-1:0][ACC_WIDTH-1:0]   acc [NUM_NODES];

    logic [IDX_W-1:0]                         coo_row;
    logic [IDX_W-1:0]                         coo_col;
    logic                                     in_range;
    logic                                     clr;
    logic                                     add_en;
    logic [IDX_W-1:0]                         add_idx;
    logic [FEATURE_COLS-1:0][ACC_WIDTH-1:0]   add_val;

    assign coo_row  = coo_rdata[2*IDX_W-1:IDX_W];
    assign coo_col  = coo_rdata[IDX_W-1:0];
    assign in_range = (int'(coo_row) < NUM_NODES) && (int'(coo_col) < NUM_NODES);
    assign coo_addr = edge_cnt;

    // The col read is issued in the same cycle the COO word arrives, so the
    // address bypasses the register in LATCH_COO.
    assign fm_wm_addr = (state == LATCH_COO) ? coo_col : fm_addr_q;

    // A new run clears everything; start is only honoured at rest.
    assign clr = start && ((state == IDLE) || (state == DONE));

    // ACC_R_C adds into the row node; ACC_C_R into the col node unless it is
    // a self-loop. A bad edge suppresses both.
    assign add_en  = pair_ok && ((state == ACC_R_C) ||
                                 ((state == ACC_C_R) && (row_q != col_q)));
    assign add_idx = (state == ACC_R_C) ? row_q : col_q;

    // Sign-extend each FM_WM element to accumulator width.
    always_comb begin
        add_val = '0;
        for (int k = 0; k < FEATURE_COLS; k++) begin
            add_val[k] = ACC_WIDTH'($signed(fm_wm_rdata[k*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Control FSM with registered strobes and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            idx_err     <= 1'b0;
            coo_rd_en   <= 1'b0;
            fm_wm_rd_en <= 1'b0;
            fm_addr_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pair_ok     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= READ_COO;
                        edge_cnt  <= '0;
                        idx_err   <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        coo_rd_en <= 1'b1;
                    end
                end
                READ_COO: begin
                    coo_rd_en   <= 1'b0;
                    fm_wm_rd_en <= 1'b1;
                    state       <= LATCH_COO;
                end
                LATCH_COO: begin
                    row_q     <= coo_row;
                    col_q     <= coo_col;
                    pair_ok   <= in_range;
                    fm_addr_q <= coo_row;
                    if (!in_range) idx_err <= 1'b1;
                    state     <= ACC_R_C;
                end
                ACC_R_C: begin
                    fm_wm_rd_en <= 1'b0;
                    fm_addr_q   <= '0;
                    state       <= ACC_C_R;
                end
                ACC_C_R: begin
                    state <= INCR;
                end
                INCR: begin
                    if (int'(edge_cnt) == NUM_EDGES - 1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        edge_cnt  <= edge_cnt + 1'b1;
                        coo_rd_en <= 1'b1;
                        state     <= READ_COO;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Accumulator array: clear on start, wrapping add in the ACC states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_NODES; n++) acc[n] <= '0;
        end else if (clr) begin
            for (int n = 0; n < NUM_NODES; n++) acc[n] <= '0;
        end else if (add_en) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (int'(add_idx) == n) begin
                    for (int k = 0; k < FEATURE_COLS; k++) begin
                        acc[n][k] <= acc[n][k] + add_val[k];
                    end
                end
            end
        end
    end

    // Readout mux; addresses past the last node read as zero.
    always_comb begin
        res_rdata = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            if (int'(res_addr) == n) res_rdata = acc[n];
        end
    end

endmodule
